fir_seq_ctl: RTL and testbench
==============================

// Module: fir_seq_ctl
// PURPOSE
//  Frame sequencer for the nibble-serial FIR processing-element chain.
//  - Accepts 8-bit samples from the host over a valid/ready handshake.
//  - Emits one shared load pulse (pe_rdy) per sample, then serializes the sample and a bias into 4-bit nibbles.
//  - Collects the 16-bit result nibble-serially from the last PE and presents it to the host as a parallel word.
//  - Sits between the host/IO wrapper and the PE chain; it is the only block that drives the chain's Rdy.
// PARAMETERS
//  PRIME    2        result frames discarded after reset/flush (chain latency in frames; 2 per single PE)
//  BIAS     16'h0000 value serialized onto pe_yin of the first PE, LSB nibble first
//  INIT_CYC 5        Rdy-low cycles after reset release, to flush the PE LoadCtl shift registers
// PORTS
//  clk         in   1   system clock, all regs posedge
//  nReset      in   1   asynchronous active-low reset
//  x_data      in   8   host sample
//  x_valid     in   1   host sample valid
//  x_ready     out  1   controller can take sample this cycle
//  y_data      out  16  assembled filter output
//  y_valid     out  1   one-cycle strobe, y_data valid; no backpressure
//  pe_rdy      out  1   shared Rdy to every PE, registered
//  pe_xin      out  4   Xin of first PE
//  pe_yin      out  4   Yin of first PE
//  pe_yout     in   4   Yout of last PE
//  pe_vld      in   1   Vld of last PE, used for the timing check
//  err_vld     out  1   sticky: pe_vld mismatch seen
//  flush_req   in   1   (FIR_CTL_FLUSH_EN only) drain request
//  flush_done  out  1   (FIR_CTL_FLUSH_EN only) one-cycle strobe
// BEHAVIOUR
//  Reset values
//  - nReset low: state=INIT, all outputs 0, prime_cnt=PRIME, err_vld=0. Applies mid-frame too.
//  - Reset mid-frame aborts the frame. Any partial result is dropped, with no y_valid.
//  FSM states: INIT, IDLE, LOAD, N0, N1, N2, N3.
//  - INIT: pe_rdy=0 for INIT_CYC cycles, x_ready=0, then go to IDLE.
//  - IDLE: x_ready=1. On x_valid, capture x_data into smp and go to LOAD.
//  - LOAD: pe_rdy=1 for exactly this cycle. pe_xin=0, pe_yin=0.
//  - N0: pe_xin=smp[3:0], pe_yin=BIAS[3:0]; capture pe_yout into res[3:0].
//  - N1: pe_xin=smp[7:4], pe_yin=BIAS[7:4]; capture res[7:4].
//  - N2: pe_xin=0, pe_yin=BIAS[11:8]; capture res[11:8].
//  - N3: pe_xin=0, pe_yin=BIAS[15:12]; capture res[15:12]. x_ready=1 here as well.
//    - x_valid in N3: capture the sample and go directly to LOAD (back-to-back frame).
//    - Otherwise go to IDLE.
//  Timing
//  - Frame period is 5 cycles minimum. pe_rdy is never high on two cycles closer than 5 apart.
//  - Result written by a frame is the PE output from PRIME frames earlier.
//  - On the cycle after N3: if prime_cnt==0, y_data<=res and y_valid=1; else prime_cnt decrements and y_valid=0.
//  - prime_cnt saturates at 0.
//  - Only one sample is buffered. An x_valid held through LOAD..N2 waits, and x_ready stays 0 there.
//  Vld check
//  - The cycle 5 after each pe_rdy pulse (LOAD of the next frame, or first IDLE cycle) must have pe_vld=1.
//  - Every other cycle, pe_vld=0 is expected. Any mismatch sets err_vld, which clears only on reset.
//  - Check is suppressed for pulses issued before the first LOAD after INIT.
//  - pe_xin/pe_yin are combinational from state and smp. All other outputs are registered.
// CONFIGURATION
//  FIR_CTL_FLUSH_EN defined
//  - In IDLE, flush_req=1 with x_valid=0 runs PRIME+1 frames with smp=0.
//  - Their results are emitted normally, with y_valid and no priming discard.
//  - flush_done pulses on the cycle after the last N3. Then prime_cnt reloads to PRIME and the FSM returns to IDLE.
//  - x_ready=0 while flushing.
//  - x_valid and flush_req together in IDLE: the sample wins and the flush is taken after that frame.
//  FIR_CTL_FLUSH_EN undefined
//  - flush_req/flush_done ports and the flush logic are absent.
//  - Data can only be drained by host zero samples.
// TESTING
//  - Reset, then hold x_valid=0 -> pe_rdy=0 for at least INIT_CYC cycles, x_ready=1 from cycle INIT_CYC+1, all outputs 0.
//  - Single PE with Cin=8'h03, BIAS=0; samples 8'h10,8'h20,8'h05 back-to-back -> y_valid only on frame 3, y_data=16'h0030.
//    A fourth sample gives 16'h0060.
//  - Back-to-back stream of 6 samples with x_valid held high -> pe_rdy pulses exactly every 5 cycles, x_ready high only in IDLE/N3.
//  - BIAS=16'h1234, Cin=0 -> after priming, every y_data=16'h1234; nibble order on pe_yin is 4,3,2,1.
//  - Force pe_vld=0 at the expected check cycle -> err_vld=1 next cycle and stays 1 until nReset.
//  - Assert nReset in N1 -> all outputs 0 next cycle, no y_valid for the aborted frame.
//    After release, PRIME results are discarded again.
//    With FIR_CTL_FLUSH_EN: flush_req after 2 samples -> 3 zero frames, flush_done after the last one.

Source files
------------

// File: rtl/fir_seq_ctl_if.sv
// Host and PE-chain signal bundle for fir_seq_ctl.
// The flush handshake exists only when FIR_CTL_FLUSH_EN is defined.
interface fir_seq_ctl_if;
  logic [7:0]  x_data;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] y_data;
  logic        y_valid;
  logic        pe_rdy;
  logic [3:0]  pe_xin;
  logic [3:0]  pe_yin;
  logic [3:0]  pe_yout;
  logic        pe_vld;
  logic        err_vld;
`ifdef FIR_CTL_FLUSH_EN
  logic        flush_req;
  logic        flush_done;

  modport slave (
    input  x_data, x_valid, pe_yout, pe_vld, flush_req,
    output x_ready, y_data, y_valid, pe_rdy, pe_xin, pe_yin, err_vld, flush_done
  );
  modport master (
    output x_data, x_valid, pe_yout, pe_vld, flush_req,
    input  x_ready, y_data, y_valid, pe_rdy, pe_xin, pe_yin, err_vld, flush_done
  );
`else
  modport slave (
    input  x_data, x_valid, pe_yout, pe_vld,
    output x_ready, y_data, y_valid, pe_rdy, pe_xin, pe_yin, err_vld
  );
  modport master (
    output x_data, x_valid, pe_yout, pe_vld,
    input  x_ready, y_data, y_valid, pe_rdy, pe_xin, pe_yin, err_vld
  );
`endif
endinterface

// File: rtl/fir_seq_ctl.sv
// Frame sequencer for the nibble-serial FIR PE chain: sample load, nibble serialisation, result assembly.
// Optional drain sequence enabled by defining FIR_CTL_FLUSH_EN.
module fir_seq_ctl #(
  parameter int unsigned PRIME    = 2,
  parameter logic [15:0] BIAS     = 16'h0000,
  parameter int unsigned INIT_CYC = 5
) (
  input logic          clk,
  input logic          nReset,
  fir_seq_ctl_if.slave bus
);
  localparam int unsigned    ICW        = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam int unsigned    PCW        = (PRIME > 0) ? $clog2(PRIME + 1) : 1;
  localparam logic [ICW-1:0] INIT_LAST  = ICW'(INIT_CYC - 1);
  localparam logic [PCW-1:0] PRIME_INIT = PCW'(PRIME);

  typedef enum logic [2:0] {INIT, IDLE, LOAD, N0, N1, N2, N3} state_t;

  state_t         state_reg, state_next;
  logic [ICW-1:0] init_cnt_reg;
  logic [PCW-1:0] prime_cnt_reg;
  logic [7:0]     smp_reg;
  logic [11:0]    res_reg;
  logic [15:0]    y_data_reg;
  logic           y_valid_reg;
  logic           pe_rdy_reg;
  logic           x_ready_reg;
  logic           err_reg;
  logic           chk_en_reg;
  logic [4:0]     rdy_dly_reg;
  logic           take_smp;
  logic           x_ready_next;
  logic           no_discard;
  logic           hold_off;
  logic [3:0]     xin;
  logic [3:0]     yin;
  logic [3:0]     bias_nib [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bias
      assign bias_nib[gi] = BIAS[4*gi +: 4];
    end
  endgenerate

`ifdef FIR_CTL_FLUSH_EN
  logic           flushing_reg;
  logic           flush_pend_reg;
  logic           flush_done_reg;
  logic [PCW-1:0] flush_cnt_reg;
  logic           flush_start;
  logic           flush_last;

  assign no_discard      = flushing_reg;
  assign hold_off        = flushing_reg | flush_pend_reg;
  assign bus.flush_done  = flush_done_reg;
`else
  assign no_discard      = 1'b0;
  assign hold_off        = 1'b0;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_reg <= INIT;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    take_smp   = 1'b0;
    xin        = 4'h0;
    yin        = 4'h0;
`ifdef FIR_CTL_FLUSH_EN
    flush_start = 1'b0;
    flush_last  = 1'b0;
`endif
    case (state_reg)
      INIT: if (init_cnt_reg == INIT_LAST) state_next = IDLE;
      IDLE: begin
        if (bus.x_valid) begin
          take_smp   = 1'b1;
          state_next = LOAD;
        end
`ifdef FIR_CTL_FLUSH_EN
        else if (bus.flush_req) begin
          flush_start = 1'b1;
          state_next  = LOAD;
        end
`endif
      end
      LOAD: state_next = N0;
      N0: begin
        xin        = smp_reg[3:0];
        yin        = bias_nib[0];
        state_next = N1;
      end
      N1: begin
        xin        = smp_reg[7:4];
        yin        = bias_nib[1];
        state_next = N2;
      end
      N2: begin
        yin        = bias_nib[2];
        state_next = N3;
      end
      N3: begin
        yin        = bias_nib[3];
        state_next = IDLE;
`ifdef FIR_CTL_FLUSH_EN
        if (flushing_reg) begin
          flush_last = (flush_cnt_reg == '0);
          if (!flush_last) state_next = LOAD;
        end else if (flush_pend_reg) begin
          flush_start = 1'b1;
          state_next  = LOAD;
        end else if (bus.x_valid) begin
          take_smp   = 1'b1;
          state_next = LOAD;
        end
`else
        if (bus.x_valid) begin
          take_smp   = 1'b1;
          state_next = LOAD;
        end
`endif
      end
      default: state_next = INIT;
    endcase
    // Ready is registered, so it is decided from where the FSM is going next
    x_ready_next = (state_next == IDLE) || ((state_next == N3) && !hold_off);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      init_cnt_reg  <= '0;
      prime_cnt_reg <= PRIME_INIT;
      smp_reg       <= '0;
      res_reg       <= '0;
      y_data_reg    <= '0;
      y_valid_reg   <= 1'b0;
      pe_rdy_reg    <= 1'b0;
      x_ready_reg   <= 1'b0;
      err_reg       <= 1'b0;
      chk_en_reg    <= 1'b0;
      rdy_dly_reg   <= '0;
`ifdef FIR_CTL_FLUSH_EN
      flushing_reg   <= 1'b0;
      flush_pend_reg <= 1'b0;
      flush_done_reg <= 1'b0;
      flush_cnt_reg  <= '0;
`endif
    end else begin
      y_valid_reg <= 1'b0;
      pe_rdy_reg  <= (state_next == LOAD);
      x_ready_reg <= x_ready_next;
      rdy_dly_reg <= {rdy_dly_reg[3:0], pe_rdy_reg};
      if (state_next == LOAD) chk_en_reg <= 1'b1;
      // The last PE must raise Vld exactly five cycles after each Rdy pulse
      if (chk_en_reg && (bus.pe_vld != rdy_dly_reg[4])) err_reg <= 1'b1;
      if (state_reg == INIT) init_cnt_reg <= init_cnt_reg + ICW'(1);
      if (take_smp) smp_reg <= bus.x_data;
      case (state_reg)
        N0:      res_reg[3:0]  <= bus.pe_yout;
        N1:      res_reg[7:4]  <= bus.pe_yout;
        N2:      res_reg[11:8] <= bus.pe_yout;
        default: ;
      endcase
      if (state_reg == N3) begin
        if (no_discard || (prime_cnt_reg == '0)) begin
          y_data_reg  <= {bus.pe_yout, res_reg};
          y_valid_reg <= 1'b1;
        end else begin
          prime_cnt_reg <= prime_cnt_reg - PCW'(1);
        end
      end
`ifdef FIR_CTL_FLUSH_EN
      flush_done_reg <= 1'b0;
      if ((state_reg == IDLE) && bus.x_valid && bus.flush_req) flush_pend_reg <= 1'b1;
      if (flush_start) begin
        flushing_reg   <= 1'b1;
        flush_pend_reg <= 1'b0;
        flush_cnt_reg  <= PRIME_INIT;
        smp_reg        <= '0;
      end else if (flushing_reg && (state_reg == N3)) begin
        if (flush_last) begin
          flushing_reg   <= 1'b0;
          flush_done_reg <= 1'b1;
          prime_cnt_reg  <= PRIME_INIT;
        end else begin
          flush_cnt_reg <= flush_cnt_reg - PCW'(1);
        end
      end
`endif
    end
  end

  assign bus.x_ready = x_ready_reg;
  assign bus.y_data  = y_data_reg;
  assign bus.y_valid = y_valid_reg;
  assign bus.pe_rdy  = pe_rdy_reg;
  assign bus.pe_xin  = xin;
  assign bus.pe_yin  = yin;
  assign bus.err_vld = err_reg;

endmodule

// File: tb/tb_fir_seq_ctl.sv
// Directed bench: two controllers (BIAS=0 with Cin=3, BIAS=16'h1234 with Cin=0), each driving a one-PE model.
module tb_fir_seq_ctl;
  localparam int INIT_CYC = 5;
  localparam logic [7:0]  STREAM [6] = '{8'h10, 8'h20, 8'h05, 8'h07, 8'h11, 8'h22};
  localparam logic [15:0] EXP0   [4] = '{16'h0030, 16'h0060, 16'h000F, 16'h0015};
  localparam logic [3:0]  EXP_YIN[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  localparam logic [3:0]  EXP_XIN[4] = '{4'h0, 4'h1, 4'h0, 4'h0};

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] x_data = 8'h00;
  logic       x_valid = 1'b0;
  logic [1:0] vld_kill = 2'b00;
`ifdef FIR_CTL_FLUSH_EN
  logic       flush_req = 1'b0;
  int         done_cnt = 0;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_seq_ctl_if bus0();
  fir_seq_ctl_if bus1();

  fir_seq_ctl #(.PRIME(2), .BIAS(16'h0000), .INIT_CYC(INIT_CYC)) dut0 (.clk(clk), .nReset(nReset), .bus(bus0));
  fir_seq_ctl #(.PRIME(2), .BIAS(16'h1234), .INIT_CYC(INIT_CYC)) dut1 (.clk(clk), .nReset(nReset), .bus(bus1));

  logic [1:0] rdy_w;
  logic [1:0] vld_w;
  logic [3:0] xin_w  [2];
  logic [3:0] yin_w  [2];
  logic [3:0] yout_w [2];

  assign bus0.x_data  = x_data;
  assign bus0.x_valid = x_valid;
  assign bus1.x_data  = x_data;
  assign bus1.x_valid = x_valid;
`ifdef FIR_CTL_FLUSH_EN
  assign bus0.flush_req = flush_req;
  assign bus1.flush_req = flush_req;
`endif
  assign rdy_w[0] = bus0.pe_rdy;
  assign rdy_w[1] = bus1.pe_rdy;
  assign xin_w[0] = bus0.pe_xin;
  assign xin_w[1] = bus1.pe_xin;
  assign yin_w[0] = bus0.pe_yin;
  assign yin_w[1] = bus1.pe_yin;
  assign bus0.pe_yout = yout_w[0];
  assign bus1.pe_yout = yout_w[1];
  assign bus0.pe_vld  = vld_w[0];
  assign bus1.pe_vld  = vld_w[1];

  // Single PE: y = Cin*x + yin, result of a frame appears two frames later, Vld 5 cycles after Rdy
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_pe
    localparam logic [15:0] CIN = (gi == 0) ? 16'h0003 : 16'h0000;
    logic [2:0]  pos;
    logic [7:0]  acc_x;
    logic [15:0] acc_y, stage1, out_word;
    always @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        pos <= 3'd0; acc_x <= 8'h00; acc_y <= 16'h0; stage1 <= 16'h0; out_word <= 16'h0;
      end else if (rdy_w[gi]) begin
        pos      <= 3'd1;
        out_word <= stage1;
        stage1   <= CIN * {8'h00, acc_x} + acc_y;
        acc_x    <= 8'h00;
        acc_y    <= 16'h0;
      end else begin
        case (pos)
          3'd1: begin acc_x[3:0] <= xin_w[gi]; acc_y[3:0] <= yin_w[gi]; end
          3'd2: begin acc_x[7:4] <= xin_w[gi]; acc_y[7:4] <= yin_w[gi]; end
          3'd3: acc_y[11:8]  <= yin_w[gi];
          3'd4: acc_y[15:12] <= yin_w[gi];
          default: ;
        endcase
        pos <= (pos != 3'd0 && pos < 3'd5) ? pos + 3'd1 : 3'd0;
      end
    end
    assign yout_w[gi] = (pos == 3'd1) ? out_word[3:0]   :
                        (pos == 3'd2) ? out_word[7:4]   :
                        (pos == 3'd3) ? out_word[11:8]  :
                        (pos == 3'd4) ? out_word[15:12] : 4'h0;
    assign vld_w[gi] = (pos == 3'd5) && !vld_kill[gi];
  end

  logic [15:0] y0_q[$];
  logic [15:0] y1_q[$];
  int          rdy_t[$];
  int          xr_cnt = 0;
  bit          mon_win = 1'b0;
  bit          cap_arm = 1'b0;
  int          nib_idx = -1;
  logic [3:0]  yin_cap [4];
  logic [3:0]  xin_cap [4];

  always @(negedge clk) begin
    if (bus0.y_valid) begin
      y0_q.push_back(bus0.y_data);
      $display("[%0d] dut0 result y_data=%h", cyc, bus0.y_data);
    end
    if (bus1.y_valid) begin
      y1_q.push_back(bus1.y_data);
      $display("[%0d] dut1 result y_data=%h", cyc, bus1.y_data);
    end
`ifdef FIR_CTL_FLUSH_EN
    if (bus0.flush_done) begin
      done_cnt++;
      $display("[%0d] dut0 flush_done", cyc);
    end
`endif
    if (mon_win) begin
      if (bus0.pe_rdy) rdy_t.push_back(cyc);
      if (bus0.x_ready && rdy_t.size() >= 1 && rdy_t.size() < 6) xr_cnt++;
    end
    if (nib_idx >= 0 && nib_idx < 4) begin
      yin_cap[nib_idx] = bus1.pe_yin;
      xin_cap[nib_idx] = bus0.pe_xin;
      nib_idx++;
    end
    if (bus1.pe_rdy && cap_arm) begin
      nib_idx = 0;
      cap_arm = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v, input bit hold);
    int n;
    n = 0;
    while (!bus0.x_ready && n < 40) begin
      tick();
      n++;
    end
    check_eq("x_ready_wait", {31'd0, bus0.x_ready}, 32'd1);
    x_data  = v;
    x_valid = 1'b1;
    $display("[%0d] send x_data=%h", cyc, v);
    tick();
    if (!hold) x_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected end of test", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check_eq("rst_x_ready", {31'd0, bus0.x_ready}, 32'd0);
    check_eq("rst_y_valid", {31'd0, bus0.y_valid}, 32'd0);
    check_eq("rst_y_data",  {16'd0, bus0.y_data},  32'd0);
    check_eq("rst_pe_rdy",  {31'd0, bus0.pe_rdy},  32'd0);
    check_eq("rst_pe_xin",  {28'd0, bus0.pe_xin},  32'd0);
    check_eq("rst_pe_yin",  {28'd0, bus1.pe_yin},  32'd0);
    check_eq("rst_err_vld", {31'd0, bus0.err_vld}, 32'd0);
    nReset = 1'b1;
    for (int k = 1; k <= INIT_CYC; k++) begin
      tick();
      check_eq($sformatf("init_x_ready_%0d", k), {31'd0, bus0.x_ready}, (k == INIT_CYC) ? 32'd1 : 32'd0);
      check_eq($sformatf("init_pe_rdy_%0d", k),  {31'd0, bus0.pe_rdy},  32'd0);
    end

    // Back-to-back stream with x_valid held high
    y0_q.delete(); y1_q.delete(); rdy_t.delete();
    mon_win = 1'b1;
    cap_arm = 1'b1;
    for (int i = 0; i < 6; i++) send(STREAM[i], 1'b1);
    x_valid = 1'b0;
    repeat (12) tick();
    mon_win = 1'b0;
    check_eq("stream_y0_count", y0_q.size(), 32'd4);
    check_eq("stream_y1_count", y1_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("stream_y0_%0d", i), (i < y0_q.size()) ? {16'd0, y0_q[i]} : 32'hDEADBEEF, {16'd0, EXP0[i]});
      check_eq($sformatf("stream_y1_%0d", i), (i < y1_q.size()) ? {16'd0, y1_q[i]} : 32'hDEADBEEF, 32'h00001234);
    end
    check_eq("rdy_pulses", rdy_t.size(), 32'd6);
    for (int i = 1; i < 6; i++)
      check_eq($sformatf("rdy_gap_%0d", i), (i < rdy_t.size()) ? rdy_t[i] - rdy_t[i-1] : 0, 32'd5);
    check_eq("x_ready_cycles", xr_cnt, 32'd5);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("yin_nib_%0d", i), {28'd0, yin_cap[i]}, {28'd0, EXP_YIN[i]});
      check_eq($sformatf("xin_nib_%0d", i), {28'd0, xin_cap[i]}, {28'd0, EXP_XIN[i]});
    end
    check_eq("stream_err0", {31'd0, bus0.err_vld}, 32'd0);
    check_eq("stream_err1", {31'd0, bus1.err_vld}, 32'd0);

    // Missing Vld on dut0 at the check cycle
    vld_kill[0] = 1'b1;
    send(8'h33, 1'b0);
    repeat (5) tick();
    check_eq("err_before", {31'd0, bus0.err_vld}, 32'd0);
    tick();
    check_eq("err_set", {31'd0, bus0.err_vld}, 32'd1);
    check_eq("err_other", {31'd0, bus1.err_vld}, 32'd0);
    vld_kill[0] = 1'b0;
    send(8'h44, 1'b0);
    repeat (8) tick();
    check_eq("err_sticky", {31'd0, bus0.err_vld}, 32'd1);

    // Reset asserted during N1
    send(8'h55, 1'b0);
    tick();
    tick();
    check_eq("n1_pe_xin", {28'd0, bus0.pe_xin}, 32'h5);
    check_eq("n1_pe_yin", {28'd0, bus1.pe_yin}, 32'h3);
    y0_q.delete(); y1_q.delete();
    nReset = 1'b0;
    tick();
    check_eq("abort_y_valid", {31'd0, bus0.y_valid}, 32'd0);
    check_eq("abort_y_data",  {16'd0, bus0.y_data},  32'd0);
    check_eq("abort_pe_rdy",  {31'd0, bus0.pe_rdy},  32'd0);
    check_eq("abort_x_ready", {31'd0, bus0.x_ready}, 32'd0);
    check_eq("abort_pe_xin",  {28'd0, bus0.pe_xin},  32'd0);
    check_eq("abort_err_vld", {31'd0, bus0.err_vld}, 32'd0);
    tick();
    nReset = 1'b1;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    x_valid = 1'b0;
    repeat (12) tick();
    check_eq("reprime_y0_count", y0_q.size(), 32'd1);
    check_eq("reprime_y0", (y0_q.size() > 0) ? {16'd0, y0_q[0]} : 32'hDEADBEEF, 32'h00000003);
    check_eq("reprime_y1", (y1_q.size() > 0) ? {16'd0, y1_q[0]} : 32'hDEADBEEF, 32'h00001234);

`ifdef FIR_CTL_FLUSH_EN
    // Two samples then a drain request
    y0_q.delete(); y1_q.delete();
    send(8'h04, 1'b0);
    send(8'h05, 1'b0);
    repeat (6) tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (25) tick();
    check_eq("flush_y_count", y0_q.size(), 32'd5);
    check_eq("flush_y_last", (y0_q.size() > 0) ? {16'd0, y0_q[y0_q.size()-1]} : 32'hDEADBEEF, 32'd0);
    check_eq("flush_done_count", done_cnt, 32'd1);
    check_eq("flush_x_ready", {31'd0, bus0.x_ready}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
